// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a bounded grant tenure.
// A holder keeps the grant while it requests, for at most MAX_HOLD
// consecutive cycles. After that the search restarts one past the holder.
// The holder is re-granted only when nobody else is asking.

// decoder3to8: binary index to one-hot vector.
module decoder3to8 (
   input  logic [2:0] idx,
   output logic [7:0] dec
);

   // Shift a single one into the indexed position.
   always_comb begin
      dec = 8'h00;
      dec[idx] = 1'b1;
   end

endmodule

module rr_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       preempt
);

   // The hold counter needs at least one bit, even when MAX_HOLD is 1.
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t         state;
   logic [2:0]     ptr;
   logic [HW-1:0]  hcnt;
   logic           win_found;
   logic [2:0]     win_idx;
   logic [7:0]     dec;
   logic           holder_req;
   logic           hold_expired;

   // The search runs ptr+1 .. ptr+8. Iterating from the farthest offset
   // toward the nearest lets the nearest set bit overwrite the others.
   // As a result, index ptr itself is considered last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      for (int k = 8; k >= 1; k--) begin
         if (req[ptr + 3'(k)]) begin
            win_found = 1'b1;
            win_idx   = ptr + 3'(k);
         end
      end
   end

   // Current holder status used by the tenure logic.
   always_comb begin
      holder_req   = req[grant_idx];
      hold_expired = (hcnt == HOLD_LAST);
   end

   // While in GRANT, ptr always equals grant_idx because both are loaded with the same winner.
   // Every re-arbitration therefore starts one past the current holder.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= 3'd7;
         hcnt        <= '0;
         grant_idx   <= 3'd0;
         grant_valid <= 1'b0;
         preempt     <= 1'b0;
      end else begin
         preempt <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  state       <= GRANT;
                  ptr         <= win_idx;
                  grant_idx   <= win_idx;
                  grant_valid <= 1'b1;
                  hcnt        <= '0;
               end
            end
            GRANT: begin
               if (holder_req && !hold_expired) begin
                  hcnt <= hcnt + HW'(1);
               end else if (holder_req) begin
                  ptr       <= win_idx;
                  grant_idx <= win_idx;
                  hcnt      <= '0;
                  preempt   <= (win_idx != grant_idx);
               end else if (win_found) begin
                  ptr       <= win_idx;
                  grant_idx <= win_idx;
                  hcnt      <= '0;
               end else begin
                  state       <= IDLE;
                  grant_idx   <= 3'd0;
                  grant_valid <= 1'b0;
                  hcnt        <= '0;
               end
            end
            default: begin
               state       <= IDLE;
               grant_idx   <= 3'd0;
               grant_valid <= 1'b0;
               hcnt        <= '0;
            end
         endcase
      end
   end

   decoder3to8 u_dec (
      .idx (grant_idx),
      .dec (dec)
   );

   // The decoded index is only meaningful while a grant is held.
   always_comb begin
      grant = grant_valid ? dec : 8'h00;
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed checks of rr_arbiter8 at MAX_HOLD = 16, 4 and 1.
// All three instances share the clock, reset and request inputs.
module tb_rr_arbiter8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;

   logic [7:0] g16, g4, g1;
   logic [2:0] i16, i4, i1;
   logic       v16, v4, v1;
   logic       p16, p4, p1;

   int tests_run;
   int tests_failed;

   rr_arbiter8 #(.MAX_HOLD(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .grant(g16), .grant_idx(i16), .grant_valid(v16), .preempt(p16)
   );

   rr_arbiter8 #(.MAX_HOLD(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .grant(g4), .grant_idx(i4), .grant_valid(v4), .preempt(p4)
   );

   rr_arbiter8 #(.MAX_HOLD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .grant(g1), .grant_idx(i1), .grant_valid(v1), .preempt(p1)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance past one rising edge so that outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Put every instance into its reset state, then release reset with no requests.
   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 8'hFF;
      for (int c = 0; c < 2; c++) begin
         tick();
         tests_run++;
         if ({g16, i16, v16, p16} !== 13'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold cyc%0d: grant=%h idx=%0d valid=%b preempt=%b, want all 0",
                     c, g16, i16, v16, p16);
         end
         tests_run++;
         if ({g4, g1, v4, v1, p4, p1} !== 20'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold_other cyc%0d: g4=%h g1=%h, want 00", c, g4, g1);
         end
      end
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (g16 !== 8'h01 || i16 !== 3'd0 || v16 !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_priority: grant=%h idx=%0d valid=%b, want 01 0 1", g16, i16, v16);
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 8'h08;
      for (int c = 0; c < 5; c++) begin
         tick();
         tests_run++;
         if (g16 !== 8'h08 || i16 !== 3'd3 || p16 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single cyc%0d: grant=%h idx=%0d preempt=%b, want 08 3 0", c, g16, i16, p16);
         end
      end
      req = 8'h00;
      tick();
      tests_run++;
      if (g16 !== 8'h00 || i16 !== 3'd0 || v16 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL single_release: grant=%h idx=%0d valid=%b, want 00 0 0", g16, i16, v16);
      end
      tick();
      tests_run++;
      if (g16 !== 8'h00 || v16 !== 1'b0 || p16 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL idle_stays: grant=%h valid=%b preempt=%b, want 00 0 0", g16, v16, p16);
      end
   endtask

   task automatic test_timeout_rotation();
      logic [7:0] exp_g;
      logic       exp_p;
      do_reset();
      req = 8'h81;
      for (int n = 1; n <= 16; n++) begin
         tick();
         exp_g = (((n - 1) / 4) % 2 == 0) ? 8'h01 : 8'h80;
         exp_p = (n > 1) && ((n - 1) % 4 == 0);
         tests_run++;
         if (g4 !== exp_g || p4 !== exp_p) begin
            tests_failed++;
            $display("[TB] FAIL timeout_rot cyc%0d: grant=%h preempt=%b, want %h %b", n, g4, p4, exp_g, exp_p);
         end
      end
   endtask

   task automatic test_sole_timeout();
      do_reset();
      req = 8'h20;
      for (int n = 1; n <= 12; n++) begin
         tick();
         tests_run++;
         if (g4 !== 8'h20 || p4 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sole_timeout cyc%0d: grant=%h preempt=%b, want 20 0", n, g4, p4);
         end
      end
   endtask

   task automatic test_handover();
      do_reset();
      req = 8'h04;
      tick();
      req = 8'h0C;
      tick();
      tests_run++;
      if (g16 !== 8'h04) begin
         tests_failed++;
         $display("[TB] FAIL handover_hold: grant=%h, want 04", g16);
      end
      req = 8'h08;
      tick();
      tests_run++;
      if (g16 !== 8'h08 || i16 !== 3'd3 || p16 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL handover: grant=%h idx=%0d preempt=%b, want 08 3 0", g16, i16, p16);
      end
   endtask

   task automatic test_reset_mid_tenure();
      do_reset();
      req = 8'h10;
      tick();
      tick();
      tests_run++;
      if (g16 !== 8'h10) begin
         tests_failed++;
         $display("[TB] FAIL midrst_setup: grant=%h, want 10", g16);
      end
      rst_n = 1'b0;
      req   = 8'h30;
      tick();
      tests_run++;
      if (g16 !== 8'h00 || p16 !== 1'b0 || i16 !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL midrst_drop: grant=%h preempt=%b idx=%0d, want 00 0 0", g16, p16, i16);
      end
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (g16 !== 8'h10 || i16 !== 3'd4) begin
         tests_failed++;
         $display("[TB] FAIL midrst_resume: grant=%h idx=%0d, want 10 4", g16, i16);
      end
   endtask

   task automatic test_hold1_rotation();
      logic [7:0] seq [3];
      logic [2:0] iseq [3];
      seq[0] = 8'h01;
      seq[1] = 8'h04;
      seq[2] = 8'h20;
      iseq[0] = 3'd0;
      iseq[1] = 3'd2;
      iseq[2] = 3'd5;
      do_reset();
      req = 8'h25;
      for (int n = 0; n < 7; n++) begin
         tick();
         tests_run++;
         if (g1 !== seq[n % 3] || i1 !== iseq[n % 3] || p1 !== (n > 0)) begin
            tests_failed++;
            $display("[TB] FAIL hold1_rot cyc%0d: grant=%h idx=%0d preempt=%b, want %h %0d %b",
                     n, g1, i1, p1, seq[n % 3], iseq[n % 3], (n > 0));
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      req          = 8'h00;
      test_reset();
      test_single();
      test_timeout_rotation();
      test_sole_timeout();
      test_handover();
      test_reset_mid_tenure();
      test_hold1_rotation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
